q_update_18bit: RTL and testbench
=================================

Q_UPDATE_18BIT -- requirements
Module: q_update_18bit

Interface
REQ-001 Parameter ALPHA_SHIFT, default 3; learning rate alpha = 2^-ALPHA_SHIFT, legal range 1..8.
REQ-002 Parameter GAMMA_SHIFT, default 3; discount gamma = 1 - 2^-GAMMA_SHIFT, legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  update request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 q_old  input  18  unsigned Q(s,a) of the action taken.
REQ-008 max_q_next  input  18  unsigned max over 9 next-state Q values, from the max-Q stage.
REQ-009 reward  input  18  signed two's-complement reward.
REQ-010 terminal  input  1  next state is terminal; discounted term forced to 0.
REQ-011 state_idx  input  15  board state index (0..19682).
REQ-012 action  input  4  cell index 0..8.
REQ-013 wr_en  output  1  one-cycle Q-table write strobe.
REQ-014 wr_addr  output  19  {state_idx, action} of the captured request.
REQ-015 wr_data  output  18  updated unsigned Q value.

Function
REQ-016 Transfer occurs on a rising edge with in_valid=1 and in_ready=1; all inputs are captured into registers at that edge.
REQ-017 FSM states are IDLE, TGT, DLT, WR; in_ready=1 only in IDLE and never while rst=1.
REQ-018 Transitions: IDLE->TGT on transfer; TGT->DLT; DLT->WR; WR->IDLE unconditionally; no other transitions.
REQ-019 TGT computes target = reward + (terminal ? 0 : max_q_next - (max_q_next >> GAMMA_SHIFT)) in 20-bit signed arithmetic.
REQ-020 DLT computes delta = target - q_old in 20-bit signed, then step = delta >>> ALPHA_SHIFT (arithmetic shift, floor rounding).
REQ-021 WR computes sum = q_old + step in 20-bit signed and saturates it: sum<0 -> 0, sum>262143 -> 262143, otherwise sum[17:0].
REQ-022 wr_en=1 for exactly one cycle, while in WR; wr_addr and wr_data are valid in that cycle and are held until the next WR.
REQ-023 Latency: wr_en is asserted on the 3rd rising edge after the transfer edge; the next transfer is possible 4 edges after the previous one.
REQ-024 in_valid asserted outside IDLE is ignored; requests are neither queued nor dropped silently, because upstream holds them until in_ready.
REQ-025 action values 9..15 are passed through unchanged; range checking belongs upstream.

Reset
REQ-026 While rst=1: FSM=IDLE, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, all internal registers 0.
REQ-027 Asserting rst mid-update aborts the update with no wr_en pulse; the first accept is possible on the first edge after rst deasserts.

Structure
REQ-028 A shared package q_pkg holds Q_W=18, STATE_W=15, ACT_W=4, INT_W=20 and the FSM state enumeration.
REQ-029 A single sub-module, q_sat_18bit, implements the 20-bit-signed to 18-bit-unsigned saturation, as a combinational block.

Verification (ALPHA_SHIFT=3, GAMMA_SHIFT=3)
REQ-030 q_old=0, max_q_next=800, reward=100, terminal=0 -> wr_data=100 with wr_en on the 3rd edge after accept.
REQ-031 q_old=1000, reward=-256, terminal=1, max_q_next=5000 -> wr_data=843 (max ignored).
REQ-032 Low saturation: q_old=10, reward=-131072, terminal=1 -> wr_data=0.
REQ-033 High saturation: q_old=262143, max_q_next=262143, reward=131071, terminal=0 -> wr_data=262143.
REQ-034 Back-to-back: in_valid held high with two requests -> in_ready low for 3 cycles, two wr_en pulses 4 cycles apart, second wr_addr matches the second request.
REQ-035 rst pulsed while in DLT -> no wr_en, outputs read 0, in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/q_pkg.sv
// Shared widths and FSM state encoding for the Q-learning update datapath.
package q_pkg;
  localparam int Q_W     = 18;
  localparam int STATE_W = 15;
  localparam int ACT_W   = 4;
  localparam int INT_W   = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TGT  = 2'd1,
    ST_DLT  = 2'd2,
    ST_WR   = 2'd3
  } q_state_e;
endpackage

// File: rtl/q_sat_18bit.sv
// Clamps a 20-bit signed sum into the unsigned 18-bit Q-value range.
module q_sat_18bit
  import q_pkg::*;
(
  input  logic signed [INT_W-1:0] sum,
  output logic        [Q_W-1:0]   q_sat
);

  always_comb begin
    q_sat = sum[Q_W-1:0];
    if (sum[INT_W-1]) begin
      q_sat = '0;
    end else if (|sum[INT_W-2:Q_W]) begin
      q_sat = '1;
    end
  end

endmodule

// File: rtl/q_update_18bit.sv
// Q(s,a) <- Q + alpha*(r + gamma*maxQ' - Q), one request per four clocks.
// state | meaning
// IDLE  | ready for a request; inputs captured on transfer
// TGT   | target = reward + discounted max next-state Q
// DLT   | step = (target - q_old) scaled by alpha
// WR    | saturated q_old + step presented with wr_en
module q_update_18bit
  import q_pkg::*;
#(
  parameter int ALPHA_SHIFT = 3,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Q_W-1:0]           q_old,
  input  logic [Q_W-1:0]           max_q_next,
  input  logic [Q_W-1:0]           reward,
  input  logic                     terminal,
  input  logic [STATE_W-1:0]       state_idx,
  input  logic [ACT_W-1:0]         action,
  output logic                     wr_en,
  output logic [STATE_W+ACT_W-1:0] wr_addr,
  output logic [Q_W-1:0]           wr_data
);

  q_state_e state, state_nxt;

  logic                     accept;
  logic [Q_W-1:0]           q_old_r;
  logic [Q_W-1:0]           max_q_r;
  logic [Q_W-1:0]           reward_r;
  logic                     terminal_r;
  logic [STATE_W+ACT_W-1:0] addr_r;
  logic [STATE_W+ACT_W-1:0] addr_hold;
  logic [Q_W-1:0]           data_hold;
  logic signed [INT_W-1:0]  target_r;
  logic signed [INT_W-1:0]  step_r;

  logic signed [INT_W-1:0]  reward_ext;
  logic signed [INT_W-1:0]  max_ext;
  logic signed [INT_W-1:0]  q_ext;
  logic signed [INT_W-1:0]  disc;
  logic signed [INT_W-1:0]  target_nxt;
  logic signed [INT_W-1:0]  delta;
  logic signed [INT_W-1:0]  step_nxt;
  logic signed [INT_W-1:0]  sum;
  logic        [Q_W-1:0]    sat_q;

  // Ready is gated by rst so upstream never sees a transfer during reset.
  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  assign reward_ext = {{(INT_W-Q_W){reward_r[Q_W-1]}}, reward_r};
  assign max_ext    = {{(INT_W-Q_W){1'b0}}, max_q_r};
  assign q_ext      = {{(INT_W-Q_W){1'b0}}, q_old_r};
  assign disc       = terminal_r ? '0 : (max_ext - (max_ext >>> GAMMA_SHIFT));
  assign target_nxt = reward_ext + disc;
  assign delta      = target_r - q_ext;
  assign step_nxt   = delta >>> ALPHA_SHIFT;
  assign sum        = q_ext + step_r;

  q_sat_18bit u_sat (
    .sum   (sum),
    .q_sat (sat_q)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_TGT;
      ST_TGT:  state_nxt = ST_DLT;
      ST_DLT:  state_nxt = ST_WR;
      ST_WR:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      q_old_r    <= '0;
      max_q_r    <= '0;
      reward_r   <= '0;
      terminal_r <= 1'b0;
      addr_r     <= '0;
      addr_hold  <= '0;
      data_hold  <= '0;
      target_r   <= '0;
      step_r     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        q_old_r    <= q_old;
        max_q_r    <= max_q_next;
        reward_r   <= reward;
        terminal_r <= terminal;
        addr_r     <= {state_idx, action};
      end
      if (state == ST_TGT) target_r <= target_nxt;
      if (state == ST_DLT) step_r   <= step_nxt;
      if (state == ST_WR) begin
        addr_hold <= addr_r;
        data_hold <= sat_q;
      end
    end
  end

  // Live result during WR, last written result afterwards.
  assign wr_en   = (state == ST_WR);
  assign wr_addr = wr_en ? addr_r : addr_hold;
  assign wr_data = wr_en ? sat_q  : data_hold;

endmodule

// File: tb/tb_q_update_18bit.sv
// Directed bench for q_update_18bit with a per-cycle reference model.
module tb_q_update_18bit;
  localparam int AS = 3;
  localparam int GS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] q_old;
  logic [17:0] max_q_next;
  logic [17:0] reward;
  logic        terminal;
  logic [14:0] state_idx;
  logic [3:0]  action;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [17:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [18:0] addr;
    logic [17:0] data;
  } exp_t;

  exp_t        pend[$];
  int          next_free = 0;
  logic [18:0] last_addr = '0;
  logic [17:0] last_data = '0;

  q_update_18bit #(.ALPHA_SHIFT(AS), .GAMMA_SHIFT(GS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q_old      (q_old),
    .max_q_next (max_q_next),
    .reward     (reward),
    .terminal   (terminal),
    .state_idx  (state_idx),
    .action     (action),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Q + floor((r + gamma*maxQ - Q) / 2^AS), clamped to 0..262143.
  function automatic int model_q(int q, int m, int r, bit t);
    int tgt, d, step, s;
    tgt = r + (t ? 0 : (m - m / (1 << GS)));
    d   = tgt - q;
    if (d >= 0) step = d / (1 << AS);
    else        step = -((-d + (1 << AS) - 1) / (1 << AS));
    s = q + step;
    if (s < 0) s = 0;
    if (s > 262143) s = 262143;
    return s;
  endfunction

  task automatic check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit   exp_ready, exp_wr;
    exp_t e;
    if (rst) begin
      pend.delete();
      next_free = 0;
      last_addr = '0;
      last_data = '0;
    end
    exp_ready = !rst && (cyc >= next_free);
    exp_wr    = !rst && pend.size() > 0 && pend[0].due == cyc;
    check("in_ready", in_ready, exp_ready);
    check("wr_en", wr_en, exp_wr);
    if (exp_wr) begin
      e = pend.pop_front();
      last_addr = e.addr;
      last_data = e.data;
    end
    check("wr_addr", wr_addr, last_addr);
    check("wr_data", wr_data, last_data);
    if (exp_ready && in_valid) begin
      e.due  = cyc + 3;
      e.addr = {state_idx, action};
      e.data = 18'(model_q(int'(q_old), int'(max_q_next), int'($signed(reward)), terminal));
      pend.push_back(e);
      next_free = cyc + 4;
    end
  end

  task automatic send(int q, int m, int r, bit t, int s, int a, bit hold);
    bit got;
    q_old      = q[17:0];
    max_q_next = m[17:0];
    reward     = r[17:0];
    terminal   = t;
    state_idx  = s[14:0];
    action     = a[3:0];
    in_valid   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    check("accept_timeout", got, 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; q_old = '0; max_q_next = '0; reward = '0;
    terminal = 1'b0; state_idx = '0; action = '0;
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(0, 800, 100, 0, 123, 4, 0);
    idle(4);
    check("lit_basic", wr_data, 100);
    check("lit_addr", wr_addr, {15'd123, 4'd4});

    send(1000, 5000, -256, 1, 19682, 8, 0);
    idle(4);
    check("lit_terminal", wr_data, 843);

    send(10, 7, -131072, 1, 5, 0, 0);
    idle(4);
    check("lit_sat_low", wr_data, 0);

    send(262143, 262143, 131071, 0, 32767, 15, 0);
    idle(4);
    check("lit_sat_high", wr_data, 262143);

    send(500, 1200, 30, 0, 777, 12, 0);
    idle(4);

    send(4000, 3000, -5, 0, 1, 1, 1);
    send(2000, 65536, 2048, 0, 2, 9, 0);
    idle(4);
    check("lit_b2b_addr", wr_addr, {15'd2, 4'd9});

    send(1234, 4321, 77, 0, 99, 3, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_data", wr_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    idle(6);

    send(100, 0, 0, 1, 7, 6, 0);
    idle(5);
    check("queue_drained", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
